// File: rtl/id_bpu_dyn_pkg.sv
// Shared decode constants and counter helpers for the ID-stage dynamic predictor.
package id_bpu_dyn_pkg;

    localparam logic [4:0] JUMP_JAL  = 5'b11011;
    localparam logic [4:0] JUMP_JALR = 5'b11001;
    localparam logic [4:0] BRANCH    = 5'b11000;

    localparam logic [1:0] CNT_SNT = 2'b00;
    localparam logic [1:0] CNT_WNT = 2'b01;
    localparam logic [1:0] CNT_WT  = 2'b10;
    localparam logic [1:0] CNT_ST  = 2'b11;

    localparam logic RST_ENABLE = 1'b1;

    function automatic logic [1:0] cnt_next(input logic [1:0] c, input logic t);
        logic [1:0] n;
        n = c;
        if (t && c != CNT_ST) n = c + 2'b01;
        else if (!t && c != CNT_SNT) n = c - 2'b01;
        return n;
    endfunction

endpackage

// File: rtl/id_bpu_dyn_ras.sv
// Circular return address stack; compiled only with ID_BPU_RAS_EN.
`ifdef ID_BPU_RAS_EN
module bpu_ras #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_push,
    input  logic            i_pop,
    input  logic [XLEN-1:0] i_push_data,
    output logic            o_valid,
    output logic [XLEN-1:0] o_top
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] r_mem [DEPTH];
    logic [PW-1:0]   r_top;
    logic [CW-1:0]   r_cnt;
    logic [PW-1:0]   w_nxt;
    logic            w_pop;

    assign w_nxt   = r_top + 1'b1;
    assign w_pop   = i_pop && !i_push && (r_cnt != '0);
    assign o_valid = (r_cnt != '0);
    assign o_top   = r_mem[r_top];

    // pointer wraps on overflow, so a push when full replaces the oldest entry
    always_ff @(posedge clk) begin
        if (rst) begin
            r_top <= '0;
            r_cnt <= '0;
        end else if (i_push) begin
            r_top <= w_nxt;
            if (r_cnt != CW'(DEPTH)) r_cnt <= r_cnt + 1'b1;
        end else if (w_pop) begin
            r_top <= r_top - 1'b1;
            r_cnt <= r_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && i_push) r_mem[w_nxt] <= i_push_data;
    end

endmodule
`endif

// File: rtl/id_bpu_dyn.sv
// ID-stage dynamic branch predictor: 2-bit PHT, JAL/JALR targets.
// Optional return address stack enabled by defining ID_BPU_RAS_EN.
module id_bpu_dyn
    import id_bpu_dyn_pkg::*;
#(
    parameter int         XLEN        = 64,
    parameter int         PHT_ENTRIES = 64,
    parameter int         PHT_IDX_W   = $clog2(PHT_ENTRIES),
    parameter logic [1:0] CNT_INIT    = 2'b01,
    parameter int         RAS_DEPTH   = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     inst_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic            id_fire_i,
    output logic            x1_read_ena,
    input  logic [XLEN-1:0] x1_data,
    output logic [XLEN-1:0] prdt_pc_o,
    output logic            prdt_taken_o,
    input  logic            upd_valid_i,
    input  logic [XLEN-1:0] upd_pc_i,
    input  logic            upd_taken_i
);
    logic [1:0]           r_pht [PHT_ENTRIES];
    logic                 w_is32;
    logic                 w_jal;
    logic                 w_jalr;
    logic                 w_br;
    logic [XLEN-1:0]      w_j_imm;
    logic [XLEN-1:0]      w_b_imm;
    logic [XLEN-1:0]      w_i_imm;
    logic [PHT_IDX_W-1:0] w_idx;
    logic [PHT_IDX_W-1:0] w_upd_idx;
    logic [1:0]           w_cnt;
    logic                 w_ras_hit;
    logic [XLEN-1:0]      w_ras_top;
    logic                 w_unused;

    assign w_is32 = (inst_i[1:0] == 2'b11);
    assign w_jal  = w_is32 && (inst_i[6:2] == JUMP_JAL);
    assign w_jalr = w_is32 && (inst_i[6:2] == JUMP_JALR);
    assign w_br   = w_is32 && (inst_i[6:2] == BRANCH);

    assign w_j_imm = {{(XLEN-20){inst_i[31]}}, inst_i[19:12],
                      inst_i[20], inst_i[30:21], 1'b0};
    assign w_b_imm = {{(XLEN-12){inst_i[31]}}, inst_i[7],
                      inst_i[30:25], inst_i[11:8], 1'b0};
    assign w_i_imm = {{(XLEN-12){inst_i[31]}}, inst_i[31:20]};

    assign w_idx     = pc_i[PHT_IDX_W+1:2];
    assign w_upd_idx = upd_pc_i[PHT_IDX_W+1:2];
    assign w_cnt     = r_pht[w_idx];

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            for (int k = 0; k < PHT_ENTRIES; k++) r_pht[k] <= CNT_INIT;
        end else if (upd_valid_i) begin
            r_pht[w_upd_idx] <= cnt_next(r_pht[w_upd_idx], upd_taken_i);
        end
    end

`ifdef ID_BPU_RAS_EN
    logic       w_call;
    logic       w_ret;
    logic       w_ras_valid;
    logic [4:0] w_rd;
    logic [4:0] w_rs1;

    assign w_rd   = inst_i[11:7];
    assign w_rs1  = inst_i[19:15];
    assign w_call = (w_jal || w_jalr) && (w_rd == 5'd1);
    // a JALR that writes x1 is treated as a call, never as a return
    assign w_ret  = w_jalr && (w_rs1 == 5'd1) && (w_rd == 5'd0)
                    && (inst_i[31:20] == 12'd0);
    assign w_ras_hit = w_ret && w_ras_valid;

    bpu_ras #(
        .XLEN  (XLEN),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_call && id_fire_i),
        .i_pop       (w_ret && id_fire_i),
        .i_push_data (pc_i + XLEN'(4)),
        .o_valid     (w_ras_valid),
        .o_top       (w_ras_top)
    );

    assign w_unused = ^{upd_pc_i[XLEN-1:PHT_IDX_W+2], upd_pc_i[1:0]};
`else
    assign w_ras_hit = 1'b0;
    assign w_ras_top = '0;
    assign w_unused  = ^{upd_pc_i[XLEN-1:PHT_IDX_W+2], upd_pc_i[1:0],
                         id_fire_i, RAS_DEPTH[0]};
`endif

    always_comb begin
        prdt_pc_o    = pc_i + XLEN'(4);
        prdt_taken_o = 1'b0;
        x1_read_ena  = 1'b0;
        if (rst == RST_ENABLE) begin
            prdt_pc_o = '0;
        end else begin
            unique case (1'b1)
                w_jal: begin
                    prdt_pc_o    = pc_i + w_j_imm;
                    prdt_taken_o = 1'b1;
                end
                w_jalr: begin
                    prdt_taken_o = 1'b1;
                    if (w_ras_hit) begin
                        prdt_pc_o = w_ras_top;
                    end else begin
                        prdt_pc_o   = (x1_data + w_i_imm) & ~XLEN'(1);
                        x1_read_ena = 1'b1;
                    end
                end
                w_br: begin
                    if (w_cnt[1]) begin
                        prdt_pc_o    = pc_i + w_b_imm;
                        prdt_taken_o = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_id_bpu_dyn.sv
// Directed self-checking bench for id_bpu_dyn; RAS steps need ID_BPU_RAS_EN.
module tb_id_bpu_dyn;
    localparam int XLEN = 64;

    localparam logic [31:0] BEQ16   = 32'h0000_0863;
    localparam logic [31:0] JALM8   = 32'hFF9F_F06F;
    localparam logic [31:0] RET     = 32'h0000_8067;
    localparam logic [31:0] JALRM4  = 32'hFFC0_8067;
    localparam logic [31:0] CALL8   = 32'h0080_00EF;
    localparam logic [31:0] JALRX1  = 32'h0000_80E7;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    logic            clk = 1'b0;
    logic            rst;
    logic [31:0]     inst_i;
    logic [XLEN-1:0] pc_i;
    logic            id_fire_i;
    logic            x1_read_ena;
    logic [XLEN-1:0] x1_data;
    logic [XLEN-1:0] prdt_pc_o;
    logic            prdt_taken_o;
    logic            upd_valid_i;
    logic [XLEN-1:0] upd_pc_i;
    logic            upd_taken_i;

    int checks   = 0;
    int failures = 0;

    id_bpu_dyn dut (
        .clk          (clk),
        .rst          (rst),
        .inst_i       (inst_i),
        .pc_i         (pc_i),
        .id_fire_i    (id_fire_i),
        .x1_read_ena  (x1_read_ena),
        .x1_data      (x1_data),
        .prdt_pc_o    (prdt_pc_o),
        .prdt_taken_o (prdt_taken_o),
        .upd_valid_i  (upd_valid_i),
        .upd_pc_i     (upd_pc_i),
        .upd_taken_i  (upd_taken_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic train(input logic [XLEN-1:0] pc, input logic t);
        upd_valid_i = 1'b1;
        upd_pc_i    = pc;
        upd_taken_i = t;
        tick();
        upd_valid_i = 1'b0;
        #1;
    endtask

    task automatic look(input logic [31:0] inst, input logic [XLEN-1:0] pc);
        inst_i = inst;
        pc_i   = pc;
        #1;
    endtask

    initial begin
        rst = 1'b1; id_fire_i = 1'b0; x1_data = 64'h2003;
        upd_valid_i = 1'b1; upd_pc_i = 64'h8000_0010; upd_taken_i = 1'b1;
        look(RET, 64'h1000);
        chk("rst_pc", prdt_pc_o, 64'h0);
        chk("rst_taken", prdt_taken_o, 1'b0);
        chk("rst_x1", x1_read_ena, 1'b0);
        tick(); tick();
        rst = 1'b0; upd_valid_i = 1'b0;

        // update during reset must not have moved the counter off WNT
        look(BEQ16, 64'h8000_0010);
        chk("beq_wnt_pc", prdt_pc_o, 64'h8000_0014);
        chk("beq_wnt_tk", prdt_taken_o, 1'b0);
        train(64'h8000_0010, 1'b1);
        chk("beq_wt_pc", prdt_pc_o, 64'h8000_0020);
        chk("beq_wt_tk", prdt_taken_o, 1'b1);

        look(BEQ16, 64'h8000_0110);
        chk("alias_tk", prdt_taken_o, 1'b1);
        look(BEQ16, 64'h8000_0014);
        chk("other_idx", prdt_taken_o, 1'b0);

        look(BEQ16, 64'h8000_0010);
        for (int i = 0; i < 5; i++) train(64'h8000_0010, 1'b1);
        chk("sat_st", prdt_taken_o, 1'b1);
        train(64'h8000_0010, 1'b0);
        chk("st_to_wt", prdt_taken_o, 1'b1);
        train(64'h8000_0010, 1'b0);
        chk("wt_to_wnt", prdt_taken_o, 1'b0);
        for (int i = 0; i < 4; i++) train(64'h8000_0010, 1'b0);
        chk("sat_snt", prdt_taken_o, 1'b0);
        train(64'h8000_0010, 1'b1);
        chk("snt_to_wnt", prdt_taken_o, 1'b0);
        train(64'h8000_0010, 1'b1);
        chk("wnt_to_wt", prdt_taken_o, 1'b1);

        look(BEQ16, 64'h8000_0040);
        upd_valid_i = 1'b1; upd_pc_i = 64'h8000_0040; upd_taken_i = 1'b1;
        #1;
        chk("same_cyc", prdt_taken_o, 1'b0);
        tick();
        upd_valid_i = 1'b0;
        #1;
        chk("next_cyc", prdt_taken_o, 1'b1);

        rst = 1'b1; tick(); rst = 1'b0;
        look(BEQ16, 64'h8000_0040);
        chk("rst_forget", prdt_taken_o, 1'b0);

        look(JALM8, 64'h1000);
        chk("jal_pc", prdt_pc_o, 64'hFF8);
        chk("jal_tk", prdt_taken_o, 1'b1);
        look(NOP, 64'h1000);
        chk("nop_pc", prdt_pc_o, 64'h1004);
        chk("nop_tk", prdt_taken_o, 1'b0);

        x1_data = 64'h2003;
        look(RET, 64'h1000);
        chk("jalr_pc", prdt_pc_o, 64'h2002);
        chk("jalr_x1", x1_read_ena, 1'b1);
        chk("jalr_tk", prdt_taken_o, 1'b1);
        look(JALRM4, 64'h1000);
        chk("jalr_imm", prdt_pc_o, 64'h1FFE);

`ifdef ID_BPU_RAS_EN
        id_fire_i = 1'b1;
        look(CALL8, 64'h100);
        chk("call_pc", prdt_pc_o, 64'h108);
        tick();
        id_fire_i = 1'b0;
        x1_data = 64'h5555;
        look(RET, 64'h108);
        chk("ret_pc", prdt_pc_o, 64'h104);
        chk("ret_x1", x1_read_ena, 1'b0);
        tick();
        chk("nofire_keep", prdt_pc_o, 64'h104);
        id_fire_i = 1'b1;
        tick();
        id_fire_i = 1'b0;
        #1;
        chk("empty_fb", prdt_pc_o, 64'h5554);
        chk("empty_x1", x1_read_ena, 1'b1);

        id_fire_i = 1'b1;
        for (int i = 2; i <= 6; i++) begin
            look(CALL8, 64'(i) << 8);
            tick();
        end
        look(RET, 64'h700);
        chk("pop0", prdt_pc_o, 64'h604);
        tick();
        chk("pop1", prdt_pc_o, 64'h504);
        tick();
        chk("pop2", prdt_pc_o, 64'h404);
        tick();
        chk("pop3", prdt_pc_o, 64'h304);
        tick();
        chk("pop4_fb", prdt_pc_o, 64'h5554);
        chk("pop4_x1", x1_read_ena, 1'b1);
        tick();

        look(JALRX1, 64'h800);
        chk("jalrx1_pc", prdt_pc_o, 64'h5554);
        tick();
        look(RET, 64'h900);
        chk("jalrx1_push", prdt_pc_o, 64'h804);
        id_fire_i = 1'b0;

        id_fire_i = 1'b1;
        look(CALL8, 64'h700);
        tick();
        id_fire_i = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        look(RET, 64'h900);
        chk("rst_ras", prdt_pc_o, 64'h5554);
        chk("rst_ras_x1", x1_read_ena, 1'b1);
`else
        id_fire_i = 1'b1;
        look(CALL8, 64'h100);
        tick();
        id_fire_i = 1'b0;
        x1_data = 64'h5555;
        look(RET, 64'h108);
        chk("noras_pc", prdt_pc_o, 64'h5554);
        chk("noras_x1", x1_read_ena, 1'b1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
